// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//
// Execute-stage sequencer that sits in front of the 32-bit ALU. It accepts
// one op at a time from decode, drives registered operands and control into
// the ALU, waits an op-class-dependent settle time, and then captures the
// result and flags into a holding register for writeback.
//
// Ports
//   clk, reset_n                      clock, async active-low reset
//   in_valid / in_ready               decode handshake
//   in_a, in_b, in_op                 operands and op code from decode
//   alu_a, alu_b, alu_ctrl            registered operands/op code to the ALU
//   alu_out, alu_zero/ovf/carry       ALU result and flags
//   res_valid / res_ready             writeback handshake
//   res_data, res_zero/ovf/carry      captured result and flags
//   res_illegal                       captured op was not a defined code
//   busy                              state is not IDLE
//
// state | meaning
// ------+--------------------------------------------
// IDLE  | no op outstanding
// EXEC  | operands driven to ALU, settle counter running
// DONE  | result held for writeback

module alu_issue_ctrl #(
  parameter int WIDTH     = 32,
  parameter int LAT_ARITH = 2,
  parameter int LAT_LOGIC = 1,
  parameter int LAT_SHIFT = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  input  logic             alu_carry,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             res_ovf,
  output logic             res_carry,
  output logic             res_illegal,
  output logic             busy
);

  if (LAT_ARITH < 1 || LAT_ARITH > 16 ||
      LAT_LOGIC < 1 || LAT_LOGIC > 16 ||
      LAT_SHIFT < 1 || LAT_SHIFT > 16) begin : g_bad_latency
    $fatal(1, "alu_issue_ctrl: latency parameters must lie in 1..16");
  end

  // Counter is loaded with L-1 so that capture lands exactly L edges after
  // acceptance; L=16 therefore still fits in 4 bits.
  localparam logic [3:0] CNT_ARITH = 4'(LAT_ARITH - 1);
  localparam logic [3:0] CNT_LOGIC = 4'(LAT_LOGIC - 1);
  localparam logic [3:0] CNT_SHIFT = 4'(LAT_SHIFT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]       alu_ctrl_q, alu_ctrl_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_zero_q, res_zero_d;
  logic             res_ovf_q, res_ovf_d;
  logic             res_carry_q, res_carry_d;
  logic             res_illegal_q, res_illegal_d;
  logic             accept;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6: op_legal = 1'b1;
      default:                            op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] op_cnt(input logic [3:0] op);
    case (op)
      4'd0, 4'd1, 4'd3: op_cnt = CNT_ARITH;
      4'd5, 4'd6:       op_cnt = CNT_SHIFT;
      default:          op_cnt = CNT_LOGIC;  // xor and every illegal code
    endcase
  endfunction

  // Combinational from res_ready so a held result and a new op can trade
  // places on the same edge.
  assign in_ready = reset_n && (state_q == IDLE || (state_q == DONE && res_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_ctrl_d    = alu_ctrl_q;
    res_data_d    = res_data_q;
    res_zero_d    = res_zero_q;
    res_ovf_d     = res_ovf_q;
    res_carry_d   = res_carry_q;
    res_illegal_d = res_illegal_q;

    case (state_q)
      IDLE: ;
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = DONE;
          if (op_legal(alu_ctrl_q)) begin
            res_data_d    = alu_out;
            res_zero_d    = alu_zero;
            res_ovf_d     = alu_ovf;
            res_carry_d   = alu_carry;
            res_illegal_d = 1'b0;
          end else begin
            res_data_d    = '0;
            res_zero_d    = 1'b0;
            res_ovf_d     = 1'b0;
            res_carry_d   = 1'b0;
            res_illegal_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Acceptance is only possible from IDLE or a consumed DONE, so it simply
    // overrides whatever the case above chose.
    if (accept) begin
      state_d    = EXEC;
      cnt_d      = op_cnt(in_op);
      alu_a_d    = in_a;
      alu_b_d    = in_b;
      alu_ctrl_d = in_op;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_ctrl_q    <= 4'd0;
      res_data_q    <= '0;
      res_zero_q    <= 1'b0;
      res_ovf_q     <= 1'b0;
      res_carry_q   <= 1'b0;
      res_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_ctrl_q    <= alu_ctrl_d;
      res_data_q    <= res_data_d;
      res_zero_q    <= res_zero_d;
      res_ovf_q     <= res_ovf_d;
      res_carry_q   <= res_carry_d;
      res_illegal_q <= res_illegal_d;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_ctrl    = alu_ctrl_q;
  assign res_valid   = (state_q == DONE);
  assign res_data    = res_data_q;
  assign res_zero    = res_zero_q;
  assign res_ovf     = res_ovf_q;
  assign res_carry   = res_carry_q;
  assign res_illegal = res_illegal_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Execute-stage sequencer directly upstream of the 32-bit ALU. It accepts one operation at a time from decode over a valid/ready handshake and drives registered, stable operands and control into the ALU. It waits an op-class-dependent number of cycles for the ALU's combinational paths to settle, then captures the result and flags into a holding register for writeback, which consumes it over a second valid/ready handshake.

## Interface
- WIDTH, 32, datapath width.
- LAT_ARITH, 2, cycles for add/sub/slt; legal 1..16.
- LAT_LOGIC, 1, cycles for xor and illegal ops; legal 1..16.
- LAT_SHIFT, 3, cycles for shifts; legal 1..16.

- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  decode presents an op.
- in_ready  out  1  sequencer can accept.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_op  in  4  ALU op code.
- alu_a  out  WIDTH  registered operand to ALU busA.
- alu_b  out  WIDTH  registered operand to ALU busB.
- alu_ctrl  out  4  registered op code to ALU ctrl.
- alu_out  in  WIDTH  ALU result.
- alu_zero, alu_ovf, alu_carry  in  1 each  ALU flags.
- res_valid  out  1  result held for writeback.
- res_ready  in  1  writeback takes result.
- res_data  out  WIDTH  captured result.
- res_zero, res_ovf, res_carry  out  1 each  captured flags.
- res_illegal  out  1  captured op was not a defined code.
- busy  out  1  state is not IDLE.

## Operation
- Op codes: 0 add, 1 sub, 2 xor, 3 slt, 5 shift left, 6 shift right. All other codes (4, 7, 8–15) are illegal.
- Op classes: arith = {0,1,3} uses LAT_ARITH; logic = {2} plus all illegal codes uses LAT_LOGIC; shift = {5,6} uses LAT_SHIFT.
- States:
  - IDLE: no op outstanding.
  - EXEC: operands driven; down-counter running.
  - DONE: result held.
- in_ready = reset_n && (state==IDLE || (state==DONE && res_ready)). This path is combinational from res_ready.
- Accept when in_valid && in_ready at a rising edge:
  - alu_a/alu_b/alu_ctrl <= in_a/in_b/in_op.
  - cnt <= L−1, where L is the class latency.
  - State -> EXEC.
  - If accepted from DONE, the old result is consumed on the same edge (back-to-back).
- EXEC behaviour at each edge:
  - If cnt != 0: cnt decrements.
  - If cnt == 0: capture res_data/res_zero/res_ovf/res_carry from the ALU inputs, set res_illegal per alu_ctrl, and go to DONE.
- Illegal op: at capture, res_data=0, res_zero=res_ovf=res_carry=0 and res_illegal=1. The ALU inputs are ignored.
- DONE:
  - res_valid=1.
  - res_ready high with no acceptance -> IDLE.
  - res_ready high with acceptance -> EXEC.
  - res_ready low -> stay in DONE, with all res_* held.
- alu_a/alu_b/alu_ctrl change only on acceptance. They stay constant through EXEC and DONE.
- res_* registers change only at capture. Their values persist in IDLE; res_valid qualifies them.
- cnt is 4 bits wide.
- Parameters are checked at elaboration: any latency outside 1..16 is a fatal error.

## Timing
- Reset (reset_n low, asynchronous):
  - State IDLE, cnt=0.
  - alu_a=alu_b=0, alu_ctrl=0.
  - res_valid=0, res_data=0, all res flags 0, res_illegal=0.
  - busy=0, in_ready=0.
- After reset deasserts, in_ready=1 in the first cycle.
- Latency:
  - Op accepted at edge k -> captured at edge k+L; res_valid is high from edge k+L.
  - L=1 -> res_valid one cycle after accept.
- Throughput: one op per L+1 cycles with res_ready held high. DONE lasts one cycle and overlaps the next acceptance.
- Reset mid-EXEC or mid-DONE: the op is aborted with no result, and all outputs return to reset values immediately.
- in_valid while busy (not DONE && res_ready): ignored. Decode must hold its op; nothing is latched.
- in_op/in_a/in_b changing during EXEC have no effect.

## Test plan
- Reset, then add 0x0000_0005 + 0x0000_0003 with the ALU model returning 8 -> res_valid 2 cycles after accept, res_data=8, res_zero=0, res_illegal=0.
- xor with the ALU model returning 0 -> res_valid 1 cycle after accept, res_zero=1; alu_ctrl=2 held until the next acceptance.
- Shift left (op 5), res_ready held low for 4 cycles -> res_valid and res_data stable for 4 cycles, in_ready=0 throughout; release -> IDLE next edge.
- Two subs offered back-to-back with res_ready=1 -> second accepted on the same edge the first result leaves; results at accept+2 and accept+5.
- in_op=4'hC, ALU model returning 0xDEADBEEF -> res_data=0, res_illegal=1, flags 0, latency 1.
- Assert reset_n low during cycle 2 of a shift -> res_valid never rises, all outputs 0, in_ready=0; next op after reset completes normally.
